hls_call_controller: RTL and testbench

- Caller-side driver for an HLS-generated top module's start/reset/clk/finished/return_val interface.
- Accepts a call request from a host over a valid/ready handshake, then resets and starts the accelerator.
- Waits for finished, or a timeout, then returns the 32-bit result, measured latency and timeout flag over a valid/ready response channel.
- Sits between a testbench/SoC host and one generated accelerator instance.

---
 rtl/hls_call_controller.sv | 154 +++++++++++++++
 tb/tb_hls_call_controller.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_call_controller.sv
// Caller-side driver for an HLS-generated accelerator: takes a host call request, resets and
// starts the accelerator, waits for finished or timeout, and returns result plus latency.
module hls_call_controller #(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1000,
  parameter int unsigned CYC_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [CYC_W-1:0] rsp_cycles,
  output logic             rsp_timeout,
  output logic             busy,
  output logic             acc_reset,
  output logic             acc_start,
  input  logic             acc_finished,
  input  logic [31:0]      acc_return_val
);

  localparam int unsigned RcW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RcW-1:0]   RstLoad     = RcW'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TimeoutLast = CYC_W'(TIMEOUT - 1);
  localparam logic [CYC_W-1:0] TimeoutVal  = CYC_W'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StRstAcc, StStart, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic [RcW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [CYC_W-1:0] rsp_cycles_q, rsp_cycles_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             busy_q, busy_d;
  logic             acc_reset_q, acc_reset_d;
  logic             acc_start_q, acc_start_d;
  logic             accept;
  logic             wait_last;

  assign req_ready = (state_q == StIdle) && !reset;
  assign accept    = req_valid && req_ready;
  assign wait_last = (cyc_q == TimeoutLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StRstAcc;
      StRstAcc: if (rst_cnt_q == '0) state_d = StStart;
      StStart:  state_d = StWait;
      StWait:   if (acc_finished || wait_last) state_d = StResp;
      StResp:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output registers are loaded from the next state so every output is a flop.
  always_comb begin
    acc_reset_d   = 1'b1;
    acc_start_d   = 1'b0;
    busy_d        = (state_d != StIdle);
    rst_cnt_d     = rst_cnt_q;
    cyc_d         = cyc_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_cycles_d  = rsp_cycles_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_d)
      StStart: begin
        acc_reset_d = 1'b0;
        acc_start_d = 1'b1;
      end
      StWait:  acc_reset_d = 1'b0;
      default: ;
    endcase

    unique case (state_q)
      StIdle: begin
        if (accept) rst_cnt_d = RstLoad;
      end
      StRstAcc: begin
        if (rst_cnt_q != '0) rst_cnt_d = rst_cnt_q - 1'b1;
      end
      StStart: begin
        cyc_d = '0;
      end
      StWait: begin
        // Finished wins over timeout, so a finish on the last permitted cycle is a success.
        if (acc_finished) begin
          rsp_data_d    = acc_return_val;
          rsp_cycles_d  = cyc_q;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
        end else if (wait_last) begin
          rsp_data_d    = '0;
          rsp_cycles_d  = TimeoutVal;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cnt_q     <= '0;
      cyc_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_cycles_q  <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      acc_reset_q   <= 1'b1;
      acc_start_q   <= 1'b0;
    end else begin
      rst_cnt_q     <= rst_cnt_d;
      cyc_q         <= cyc_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_cycles_q  <= rsp_cycles_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      acc_reset_q   <= acc_reset_d;
      acc_start_q   <= acc_start_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_cycles  = rsp_cycles_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;
  assign acc_reset   = acc_reset_q;
  assign acc_start   = acc_start_q;

endmodule

// File: tb/tb_hls_call_controller.sv
// Bench for hls_call_controller: behavioural accelerator model plus a call-level reference
// computed from the finish delay, TIMEOUT and RST_CYCLES.
module tb_hls_call_controller;

  localparam int RstCycles = 2;
  localparam int Timeout   = 20;
  localparam int CycW      = 16;

  logic            clk;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic [CycW-1:0] rsp_cycles;
  logic            rsp_timeout;
  logic            busy;
  logic            acc_reset;
  logic            acc_start;
  logic            acc_finished = 1'b0;
  logic [31:0]     acc_return_val = 32'h0;

  int checks = 0;
  int errors = 0;

  hls_call_controller #(
    .RST_CYCLES(RstCycles),
    .TIMEOUT   (Timeout),
    .CYC_W     (CycW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_cycles    (rsp_cycles),
    .rsp_timeout   (rsp_timeout),
    .busy          (busy),
    .acc_reset     (acc_reset),
    .acc_start     (acc_start),
    .acc_finished  (acc_finished),
    .acc_return_val(acc_return_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accelerator model: finished rises on WAIT cycle index acc_d (never if negative).
  // In stale mode a finished flag survives acc_reset and is only dropped by the next start.
  int          acc_d = -1;
  logic [31:0] acc_val = 32'h0;
  bit          stale_mode = 1'b0;
  int          k = 0;

  always @(negedge clk) begin
    if (acc_start) begin
      k = 0;
      acc_finished = 1'b0;
      acc_return_val = acc_val;
    end else if (acc_reset) begin
      k = 0;
      if (!stale_mode) acc_finished = 1'b0;
    end else begin
      k++;
      if (acc_d >= 0 && k > acc_d) acc_finished = 1'b1;
    end
  end

  // Per-call observations
  logic [31:0]     r_data;
  logic [CycW-1:0] r_cyc;
  logic            r_to;
  int              r_lat, r_wait, r_rst_hi, r_start_at, r_starts;
  bit              r_stable, r_post_ok, r_hung;

  // Reference expectations
  logic [31:0]     e_data;
  logic [CycW-1:0] e_cyc;
  logic            e_to;
  int              e_lat;

  function automatic void ref_call(input int d, input logic [31:0] v);
    if (d >= 0 && d < Timeout) begin
      e_data = v;
      e_cyc  = CycW'(d);
      e_to   = 1'b0;
      e_lat  = RstCycles + 2 + d;
    end else begin
      e_data = 32'h0;
      e_cyc  = CycW'(Timeout);
      e_to   = 1'b1;
      e_lat  = RstCycles + 2 + Timeout - 1;
    end
  endfunction

  // Runs one call; entered and left at posedge+1.
  task automatic run_call(input int d, input logic [31:0] v, input int ready_delay,
                          input bit hold_req);
    acc_d = d;
    acc_val = v;
    req_valid = 1'b1;
    r_wait = 0;
    r_hung = 1'b0;
    r_starts = 0;
    r_stable = 1'b1;
    r_post_ok = 1'b0;
    while (!req_ready && r_wait < 50) begin
      @(posedge clk); #1;
      r_wait++;
    end
    if (!req_ready) begin
      r_hung = 1'b1;
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!hold_req) req_valid = 1'b0;
    r_lat = 0;
    r_rst_hi = 0;
    r_start_at = -1;
    while (!rsp_valid && r_lat < 200) begin
      if (acc_start) begin
        r_starts++;
        if (r_start_at < 0) r_start_at = r_lat;
        if (acc_reset) r_stable = 1'b0;
      end else if (acc_reset && r_start_at < 0) begin
        r_rst_hi++;
      end
      @(posedge clk); #1;
      r_lat++;
    end
    if (!rsp_valid) begin
      r_hung = 1'b1;
      req_valid = 1'b0;
      return;
    end
    r_data = rsp_data;
    r_cyc  = rsp_cycles;
    r_to   = rsp_timeout;
    if (req_ready !== 1'b0 || busy !== 1'b1 || acc_reset !== 1'b1) r_stable = 1'b0;
    for (int i = 0; i < ready_delay; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== r_data || rsp_cycles !== r_cyc ||
          rsp_timeout !== r_to || req_ready !== 1'b0 || busy !== 1'b1 || acc_reset !== 1'b1)
        r_stable = 1'b0;
      if (acc_start) r_starts++;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    r_post_ok = (rsp_valid === 1'b0 && req_ready === 1'b1 && busy === 1'b0 &&
                 acc_reset === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_ready got %b want 0", req_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({acc_reset, acc_start, busy, rsp_valid, rsp_timeout} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 10000",
               {acc_reset, acc_start, busy, rsp_valid, rsp_timeout});
    end
    checks++;
    if (rsp_data !== 32'h0 || rsp_cycles !== '0) begin
      errors++;
      $display("FAIL reset_rsp got %h/%0d want 0/0", rsp_data, rsp_cycles);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_normal();
    stale_mode = 1'b0;
    run_call(5, 32'd6, 0, 1'b0);
    ref_call(5, 32'd6);
    checks++;
    if (r_hung) begin
      errors++;
      $display("FAIL normal_hang got hung want response");
    end
    checks++;
    if (r_data !== e_data || r_cyc !== e_cyc || r_to !== e_to) begin
      errors++;
      $display("FAIL normal_rsp got %h/%0d/%b want %h/%0d/%b", r_data, r_cyc, r_to,
               e_data, e_cyc, e_to);
    end
    checks++;
    if (r_lat !== e_lat) begin
      errors++;
      $display("FAIL normal_latency got %0d want %0d", r_lat, e_lat);
    end
    checks++;
    if (r_rst_hi !== RstCycles || r_start_at !== RstCycles) begin
      errors++;
      $display("FAIL normal_rst_phase got %0d/%0d want %0d/%0d", r_rst_hi, r_start_at,
               RstCycles, RstCycles);
    end
    checks++;
    if (r_starts !== 1 || !r_stable || !r_post_ok) begin
      errors++;
      $display("FAIL normal_ctrl got starts=%0d stable=%b post=%b want 1/1/1", r_starts,
               r_stable, r_post_ok);
    end
  endtask

  task automatic test_timeout();
    run_call(-1, 32'hCAFE_F00D, 0, 1'b0);
    ref_call(-1, 32'hCAFE_F00D);
    checks++;
    if (r_hung || r_data !== e_data || r_cyc !== e_cyc || r_to !== e_to) begin
      errors++;
      $display("FAIL timeout_rsp got %h/%0d/%b hung=%b want %h/%0d/%b", r_data, r_cyc, r_to,
               r_hung, e_data, e_cyc, e_to);
    end
    checks++;
    if (r_lat !== e_lat) begin
      errors++;
      $display("FAIL timeout_latency got %0d want %0d", r_lat, e_lat);
    end
    checks++;
    if (!r_stable || !r_post_ok) begin
      errors++;
      $display("FAIL timeout_acc_reset got stable=%b post=%b want 1/1", r_stable, r_post_ok);
    end
  endtask

  task automatic test_boundary();
    run_call(Timeout - 1, 32'hA5A5_0019, 0, 1'b0);
    ref_call(Timeout - 1, 32'hA5A5_0019);
    checks++;
    if (r_hung || r_data !== e_data || r_cyc !== e_cyc || r_to !== e_to) begin
      errors++;
      $display("FAIL boundary_rsp got %h/%0d/%b want %h/%0d/%b", r_data, r_cyc, r_to,
               e_data, e_cyc, e_to);
    end
    checks++;
    if (r_lat !== e_lat) begin
      errors++;
      $display("FAIL boundary_latency got %0d want %0d", r_lat, e_lat);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] v;
    v = $urandom;
    run_call(4, v, 10, 1'b1);
    ref_call(4, v);
    checks++;
    if (r_hung || r_data !== e_data || r_cyc !== e_cyc || r_to !== e_to) begin
      errors++;
      $display("FAIL bp_rsp got %h/%0d/%b want %h/%0d/%b", r_data, r_cyc, r_to,
               e_data, e_cyc, e_to);
    end
    checks++;
    if (!r_stable) begin
      errors++;
      $display("FAIL bp_stable got 0 want 1");
    end
    checks++;
    if (r_starts !== 1 || !r_post_ok) begin
      errors++;
      $display("FAIL bp_starts got %0d post=%b want 1/1", r_starts, r_post_ok);
    end
  endtask

  task automatic test_back_to_back();
    stale_mode = 1'b1;
    run_call(3, 32'h1234_5678, 0, 1'b0);
    checks++;
    if (r_hung || r_data !== 32'h1234_5678 || r_cyc !== 16'd3 || r_to !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got %h/%0d/%b want 12345678/3/0", r_data, r_cyc, r_to);
    end
    run_call(6, 32'hDEAD_BEEF, 0, 1'b0);
    checks++;
    if (r_hung || r_data !== 32'hDEAD_BEEF || r_cyc !== 16'd6 || r_to !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got %h/%0d/%b want deadbeef/6/0", r_data, r_cyc, r_to);
    end
    checks++;
    if (r_wait !== 0 || r_rst_hi !== RstCycles || r_lat !== RstCycles + 2 + 6) begin
      errors++;
      $display("FAIL b2b_timing got wait=%0d rst=%0d lat=%0d want 0/%0d/%0d", r_wait,
               r_rst_hi, r_lat, RstCycles, RstCycles + 8);
    end
    stale_mode = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int n;
    acc_d = -1;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (RstCycles + 2 + 5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || acc_reset !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midwait_in_wait got busy=%b rst=%b vld=%b want 1/0/0", busy, acc_reset,
               rsp_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midwait_ready_in_reset got %b want 0", req_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({acc_reset, acc_start, busy, rsp_valid, req_ready} !== 5'b10001) begin
      errors++;
      $display("FAIL midwait_after_reset got %b want 10001",
               {acc_reset, acc_start, busy, rsp_valid, req_ready});
    end
    run_call(4, 32'h0BAD_CAFE, 1, 1'b0);
    ref_call(4, 32'h0BAD_CAFE);
    checks++;
    if (r_hung || r_data !== e_data || r_cyc !== e_cyc || r_lat !== e_lat) begin
      errors++;
      $display("FAIL midwait_next_call got %h/%0d lat=%0d want %h/%0d lat=%0d", r_data, r_cyc,
               r_lat, e_data, e_cyc, e_lat);
    end
  endtask

  task automatic test_random();
    int d;
    logic [31:0] v;
    for (int i = 0; i < 25; i++) begin
      d = int'($urandom_range(0, 25));
      if (d > 22) d = -1;
      v = $urandom;
      stale_mode = bit'($urandom_range(0, 1));
      run_call(d, v, int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
      ref_call(d, v);
      checks++;
      if (r_hung || r_data !== e_data || r_cyc !== e_cyc || r_to !== e_to) begin
        errors++;
        $display("FAIL rand%0d_rsp d=%0d got %h/%0d/%b want %h/%0d/%b", i, d, r_data, r_cyc,
                 r_to, e_data, e_cyc, e_to);
      end
      checks++;
      if (r_lat !== e_lat || r_starts !== 1 || !r_stable || !r_post_ok) begin
        errors++;
        $display("FAIL rand%0d_ctrl got lat=%0d starts=%0d st=%b post=%b want %0d/1/1/1", i,
                 r_lat, r_starts, r_stable, r_post_ok, e_lat);
      end
    end
    stale_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_boundary();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
